// File: rtl/error_calc_avg.sv
// rtl/error_calc_avg.sv - multi-channel windowed error average with saturation
//
// Purpose: per channel, error = sat(floor(sum(meas - setpoint) / 2^AVG_LOG2)),
//          produced once per 2^AVG_LOG2 accepted samples with a one-cycle strobe.
// Ports:
//   clk        rising-edge clock
//   reset_b    asynchronous active-low reset
//   in_valid   accept this cycle's adc_meas/setpoint as a sample
//   clear      synchronous window restart (wins over in_valid)
//   adc_meas   NCH unsigned measurements, channel k at [k*DATA_W +: DATA_W]
//   setpoint   NCH unsigned setpoints, packed the same way
//   deadband   (ERROR_CALC_DEADBAND_EN only) shared |avg| threshold forcing error to 0
//   error      NCH signed averaged errors, registered, held between windows
//   err_valid  one-cycle strobe marking a new error word
//   sat        per-channel clamp flag for the current error word
// Optional feature macro: ERROR_CALC_DEADBAND_EN
module error_calc_avg #(
    parameter int DATA_W   = 16,
    parameter int NCH      = 2,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  in_valid,
    input  logic                  clear,
    input  logic [NCH*DATA_W-1:0] adc_meas,
    input  logic [NCH*DATA_W-1:0] setpoint,
`ifdef ERROR_CALC_DEADBAND_EN
    input  logic [DATA_W-2:0]     deadband,
`endif
    output logic [NCH*DATA_W-1:0] error,
    output logic                  err_valid,
    output logic [NCH-1:0]        sat
);

    localparam int ACC_W = DATA_W + 1 + AVG_LOG2;
    // A zero-width counter is illegal, so AVG_LOG2=0 keeps a 1-bit counter pinned at 0.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(AVG_LOG2+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(AVG_LOG2+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc_q [NCH];
    logic signed [ACC_W-1:0]  acc_d [NCH];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NCH*DATA_W-1:0]    error_q, error_d;
    logic [NCH-1:0]           sat_q, sat_d;
    logic                     valid_q, valid_d;

    logic                     accept;
    logic                     close;
    logic [DATA_W:0]          diff_u  [NCH];
    logic signed [ACC_W-1:0]  sum     [NCH];
    logic signed [ACC_W-1:0]  avg     [NCH];
    logic signed [DATA_W-1:0] avg_sat [NCH];
    logic [NCH-1:0]           clamp;
    logic [NCH-1:0]           zero_out;
`ifdef ERROR_CALC_DEADBAND_EN
    logic signed [DATA_W:0]   avg_ext [NCH];
    logic [DATA_W:0]          mag     [NCH];
`endif

    always_comb begin
        accept  = in_valid && !clear;
        close   = accept && (cnt_q == LAST_CNT);
        cnt_d   = cnt_q;
        error_d = error_q;
        sat_d   = sat_q;
        valid_d = close;
        clamp   = '0;
        zero_out = '0;

        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (AVG_LOG2 == 0) ? '0 : cnt_q + CNT_W'(1);
        end

        for (int k = 0; k < NCH; k++) begin
            // Zero-extended subtraction in DATA_W+1 bits cannot overflow.
            diff_u[k] = {1'b0, adc_meas[k*DATA_W +: DATA_W]} - {1'b0, setpoint[k*DATA_W +: DATA_W]};
            sum[k]    = acc_q[k] + ACC_W'(signed'(diff_u[k]));
            avg[k]    = sum[k] >>> AVG_LOG2;

            if (avg[k] > MAX_V) begin
                avg_sat[k] = MAX_V[DATA_W-1:0];
                clamp[k]   = 1'b1;
            end else if (avg[k] < MIN_V) begin
                avg_sat[k] = MIN_V[DATA_W-1:0];
                clamp[k]   = 1'b1;
            end else begin
                avg_sat[k] = avg[k][DATA_W-1:0];
            end

`ifdef ERROR_CALC_DEADBAND_EN
            // Magnitude needs DATA_W+1 bits so that |-2^(DATA_W-1)| is representable.
            avg_ext[k]  = (DATA_W+1)'(avg_sat[k]);
            mag[k]      = avg_ext[k][DATA_W] ? unsigned'(-avg_ext[k]) : unsigned'(avg_ext[k]);
            zero_out[k] = (mag[k] <= {2'b00, deadband});
`endif

            if (clear || close) begin
                acc_d[k] = '0;
            end else if (accept) begin
                acc_d[k] = sum[k];
            end else begin
                acc_d[k] = acc_q[k];
            end

            if (close) begin
                sat_d[k] = clamp[k];
                error_d[k*DATA_W +: DATA_W] = zero_out[k] ? '0 : avg_sat[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
            cnt_q   <= '0;
            error_q <= '0;
            sat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= acc_d[k];
            end
            cnt_q   <= cnt_d;
            error_q <= error_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign error     = error_q;
    assign sat       = sat_q;
    assign err_valid = valid_q;

endmodule

// File: doc/error_calc_avg.md
# error_calc_avg

Parametrised, multi-channel successor to the single-channel error stage of the digital PI loop. Each accepted sample computes, for every channel, the difference between an ADC measurement and a setpoint, averages it over 2^AVG_LOG2 accepted samples, saturates it to a signed DATA_W result, and presents it with a one-cycle valid strobe. It sits between the ADC capture logic and the PI controller and feeds the controller one averaged error word per channel per window.

## Interface
- DATA_W, 16: width of each measurement, setpoint and error word.
- NCH, 2: number of independent channels.
- AVG_LOG2, 2: log2 of the averaging window length. 0 means no averaging.
- clk  in  1  clock; all logic is rising-edge.
- reset_b  in  1  reset, asynchronous and active-low.
- in_valid  in  1  marks the current cycle's inputs as a sample to accept.
- clear  in  1  synchronous window restart.
- adc_meas  in  NCH*DATA_W  unsigned measurements; channel k is bits [k*DATA_W +: DATA_W].
- setpoint  in  NCH*DATA_W  unsigned setpoints, packed the same way.
- error  out  NCH*DATA_W  signed averaged errors, packed the same way; registered.
- err_valid  out  1  one-cycle strobe marking a new error word.
- sat  out  NCH  per-channel saturation flag for the current error word; registered.

## Operation
- Per-channel difference: diff = meas − setpoint, with both operands zero-extended to DATA_W+1 bits. The result is signed DATA_W+1 bits and never overflows.
- Accumulator per channel: signed DATA_W+1+AVG_LOG2 bits. It adds diff on every cycle with in_valid=1 and clear=0.
- Sample counter: AVG_LOG2 bits. It increments on each accepted sample and wraps from 2^AVG_LOG2−1 to 0.
- Window close is the accepted sample taken when count = 2^AVG_LOG2−1. On that edge:
  - avg = (acc + diff) >>> AVG_LOG2. The shift is arithmetic, so it floors toward −∞.
  - avg is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and written to error.
  - sat[k] = 1 if channel k was clamped, else 0.
  - err_valid is set to 1, and the accumulators load 0.
- On every other edge err_valid = 0. error and sat hold their values until the next window close.
- Gaps in in_valid are allowed. Samples need not be consecutive.
- clear=1: the accumulators and counter load 0 and err_valid = 0. error and sat hold.
- clear and in_valid in the same cycle: clear wins and the sample is discarded.
- AVG_LOG2=0: every accepted sample closes a window. The counter is absent or held at 0.

## Timing
- Reset (reset_b=0, takes effect immediately): error=0, sat=0, err_valid=0, accumulators=0, counter=0.
- Reset asserted mid-window: the partial window is lost. After release, the next window starts with the first accepted sample.
- Latency: error, sat and err_valid change on the clock edge that accepts the window-closing sample. They are visible in the cycle that follows.
- Throughput: one sample per cycle, and one error word per 2^AVG_LOG2 accepted samples.
- err_valid is a pulse. There is no back-pressure, so the consumer must capture error while err_valid=1 or before the next window closes.

## Configuration
- ERROR_CALC_DEADBAND_EN defined:
  - Adds input port deadband, DATA_W−1 bits, unsigned, shared by all channels.
  - At window close, if |avg| ≤ deadband after saturation, error[k] = 0. sat[k] is unaffected.
  - deadband is sampled on the window-closing edge.
- Macro undefined: the port does not exist and no deadband logic is built. error is the saturated average.

## Test plan
All scenarios use DATA_W=16, NCH=2, AVG_LOG2=2.
- Reset: hold reset_b=0 for any inputs -> error=0, sat=0, err_valid=0. Drop reset_b asynchronously mid-window -> the counter restarts, and the next err_valid comes only after 4 new accepted samples.
- Average: ch0 meas=1000, set=900; ch1 meas=500, set=600; 4 consecutive valid samples -> one err_valid pulse after the 4th edge, error ch0=100, ch1=−100, sat=0.
- Saturation: ch0 meas=65535, set=0; ch1 meas=0, set=65535; 4 samples -> ch0=32767, ch1=−32768, sat=2'b11.
- Floor and gaps: ch0 diffs −1, 0, 0, 0 with idle cycles between samples -> error ch0=−1, and err_valid fires only on the 4th accepted sample.
- Clear: 2 samples with diff 40, then clear together with in_valid, then 4 samples with diff 8 -> a single err_valid, error=8, and the sample taken with clear is discarded.
- With ERROR_CALC_DEADBAND_EN: deadband=10 and avg=7 -> error=0. With avg=11 -> error=11.
